// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
// mem_lsu: multi-cycle load/store unit for the MEM stage.
// Wishbone-style bus master with alignment, bus-fault and LL/SC handling.
module mem_lsu #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              except_i,
  input  logic              flush_i,
  input  logic              llbit_clr_i,
  output logic              stallreq_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        exc_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              llbit_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_adr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_dat_o,
  input  logic [31:0]       bus_dat_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i
);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t            state_q;
  logic [3:0]        op_q;
  logic [1:0]        lane_q;
  logic              hi_q;
  logic              killed_q;
  logic [TW-1:0]     tmo_q;
  logic              llbit_q;
  logic              done_q;
  logic [1:0]        exc_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] badv_q;
  logic              cyc_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;

  logic        op_ok, is_b, is_h, is_w, is_st, is_sc;
  logic        misal, accept;
  logic [1:0]  lane_d;
  logic        hi_d;
  logic [3:0]  sel_d;
  logic [31:0] dat_d;

  // Classify the presented op; build its lane select and replicated data
  always_comb begin
    op_ok = 1'b1;
    is_b  = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    is_st = 1'b0;
    is_sc = 1'b0;
    unique case (op_i)
      OP_LB, OP_LBU: is_b = 1'b1;
      OP_LH, OP_LHU: is_h = 1'b1;
      OP_LW, OP_LL:  is_w = 1'b1;
      OP_SB: begin is_b = 1'b1; is_st = 1'b1; end
      OP_SH: begin is_h = 1'b1; is_st = 1'b1; end
      OP_SW: begin is_w = 1'b1; is_st = 1'b1; end
      OP_SC: begin
        is_w  = 1'b1;
        is_st = 1'b1;
        is_sc = 1'b1;
      end
      default: op_ok = 1'b0;
    endcase
    misal  = (is_h & addr_i[0]) | (is_w & |addr_i[1:0]);
    accept = (state_q == S_IDLE) & req_valid_i & op_ok
           & ~except_i & ~flush_i;
    lane_d = BIG_ENDIAN ? ~addr_i[1:0] : addr_i[1:0];
    hi_d   = BIG_ENDIAN ? ~addr_i[1] : addr_i[1];
    if (is_b) begin
      sel_d = 4'b0001 << lane_d;
      dat_d = {4{wdata_i[7:0]}};
    end else if (is_h) begin
      sel_d = hi_d ? 4'b1100 : 4'b0011;
      dat_d = {2{wdata_i[15:0]}};
    end else begin
      sel_d = 4'b1111;
      dat_d = wdata_i;
    end
  end

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_v;
  logic        tmo_hit, term, fault, kill;

  // Extract and extend the returned load; decide how BUS terminates
  always_comb begin
    byte_v = 8'(bus_dat_i >> {lane_q, 3'b000});
    half_v = hi_q ? bus_dat_i[31:16] : bus_dat_i[15:0];
    unique case (op_q)
      OP_LB:        ld_v = {{24{byte_v[7]}}, byte_v};
      OP_LBU:       ld_v = {24'd0, byte_v};
      OP_LH:        ld_v = {{16{half_v[15]}}, half_v};
      OP_LHU:       ld_v = {16'd0, half_v};
      OP_LW, OP_LL: ld_v = bus_dat_i;
      OP_SC:        ld_v = 32'd1;
      default:      ld_v = 32'd0;
    endcase
    tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
    term    = bus_ack_i | bus_err_i | tmo_hit;
    fault   = bus_err_i | (tmo_hit & ~bus_ack_i);
    kill    = killed_q | flush_i;
  end

  // Transaction FSM with registered bus and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 4'd0;
      lane_q   <= 2'd0;
      hi_q     <= 1'b0;
      killed_q <= 1'b0;
      tmo_q    <= '0;
      llbit_q  <= 1'b0;
      done_q   <= 1'b0;
      exc_q    <= EXC_NONE;
      rdata_q  <= 32'd0;
      badv_q   <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (accept) begin
          op_q     <= op_i;
          lane_q   <= lane_d;
          hi_q     <= hi_d;
          killed_q <= 1'b0;
          tmo_q    <= '0;
          badv_q   <= addr_i;
          if (misal) begin
            state_q <= S_RESP;
            done_q  <= 1'b1;
            exc_q   <= is_st ? EXC_ADES : EXC_ADEL;
            rdata_q <= 32'd0;
          end else if (is_sc && !llbit_q) begin
            state_q <= S_RESP;
            done_q  <= 1'b1;
            exc_q   <= EXC_NONE;
            rdata_q <= 32'd0;
          end else begin
            state_q <= S_BUS;
            cyc_q   <= 1'b1;
            we_q    <= is_st;
            adr_q   <= {addr_i[ADDR_W-1:2], 2'b00};
            sel_q   <= sel_d;
            dat_q   <= dat_d;
          end
        end
        S_BUS: begin
          if (flush_i) killed_q <= 1'b1;
          if (term) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            if (kill) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
              exc_q   <= fault ? EXC_BUS : EXC_NONE;
              rdata_q <= fault ? 32'd0 : ld_v;
              if (!fault && op_q == OP_LL) llbit_q <= 1'b1;
              if (!fault && op_q == OP_SC) llbit_q <= 1'b0;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (llbit_clr_i) llbit_q <= 1'b0;
    end
  end

  assign stallreq_o = accept | (state_q == S_BUS);
  assign done_o     = done_q & ~flush_i;
  assign rdata_o    = rdata_q;
  assign exc_o      = exc_q;
  assign badvaddr_o = badv_q;
  assign llbit_o    = llbit_q;
  assign bus_cyc_o  = cyc_q;
  assign bus_stb_o  = cyc_q;
  assign bus_we_o   = we_q;
  assign bus_adr_o  = adr_q;
  assign bus_sel_o  = sel_q;
  assign bus_dat_o  = dat_q;
endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
// tb_mem_lsu: directed bench for mem_lsu with a transaction-level model.
// Big-endian instance with a short bus timeout.
module tb_mem_lsu;
  localparam int TMO = 4;
  localparam bit BE  = 1'b1;

  localparam logic [3:0] NONE = 4'd0;
  localparam logic [3:0] LB   = 4'd1;
  localparam logic [3:0] LBU  = 4'd2;
  localparam logic [3:0] LH   = 4'd3;
  localparam logic [3:0] LHU  = 4'd4;
  localparam logic [3:0] LW   = 4'd5;
  localparam logic [3:0] SB   = 4'd6;
  localparam logic [3:0] SH   = 4'd7;
  localparam logic [3:0] SW   = 4'd8;
  localparam logic [3:0] LL   = 4'd9;
  localparam logic [3:0] SC   = 4'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic        except_i, flush_i, llbit_clr_i;
  logic        stallreq_o, done_o, llbit_o;
  logic [31:0] rdata_o;
  logic [1:0]  exc_o;
  logic [31:0] badvaddr_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o, bus_dat_i;
  logic        bus_ack_i, bus_err_i;

  mem_lsu #(.ADDR_W(32), .TIMEOUT(TMO), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .op_i(op_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .except_i(except_i), .flush_i(flush_i),
    .llbit_clr_i(llbit_clr_i),
    .stallreq_o(stallreq_o), .done_o(done_o),
    .rdata_o(rdata_o), .exc_o(exc_o),
    .badvaddr_o(badvaddr_o), .llbit_o(llbit_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle expectations and model state
  bit          chk_en = 0;
  bit          e_stall, e_cyc, e_done, e_we, e_rdchk;
  logic [31:0] e_adr, e_dat, e_rdata, e_badv;
  logic [3:0]  e_sel;
  logic [1:0]  e_exc;
  bit          m_llbit = 0;

  int          cyc_n = 0;
  int          acc_at, done_at, cyc_rise, ncyc;
  bit          prev_cyc = 0;
  logic [31:0] last_rdata, last_badv, last_dat;
  logic [1:0]  last_exc;
  logic [3:0]  last_sel;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Spec-level outcome of one op: bus request and result
  function automatic void predict(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] rd, input bit ll,
    output bit bus, output bit we, output logic [3:0] sel,
    output logic [31:0] dat, output logic [1:0] mexc,
    output logic [31:0] ld, output bit ldchk);
    int size, o, lane;
    bit st, sgn;
    logic [31:0] v, b;
    size = (op == LB || op == LBU || op == SB) ? 1 :
           (op == LH || op == LHU || op == SH) ? 2 : 4;
    st   = (op == SB || op == SH || op == SW || op == SC);
    sgn  = (op == LB || op == LH);
    bus = 0; we = st; sel = 0; dat = 0; mexc = 0; ld = 0;
    ldchk = !st || op == SC;
    if (a % size != 0) begin
      mexc = st ? 2'd2 : 2'd1;
      return;
    end
    if (op == SC && !ll) return;
    bus = 1;
    v = 0;
    for (int k = 0; k < size; k++) begin
      o = int'(a % 4) + k;
      lane = BE ? 3 - o : o;
      sel[lane] = 1'b1;
      b = (rd >> (8 * lane)) & 32'hFF;
      if (BE) v = (v << 8) | b;
      else v = v | (b << (8 * k));
    end
    for (int i = 0; i < 4; i++)
      dat = dat | (((wd >> (8 * (i % size))) & 32'hFF) << (8 * i));
    if (sgn && v[8 * size - 1]) v = v | (32'hFFFFFFFF << (8 * size));
    if (op == SC) ld = 1;
    else if (!st) ld = v;
  endfunction

  // Compare process: DUT against expectations every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallreq", stallreq_o, e_stall);
      chk("bus_cyc", bus_cyc_o, e_cyc);
      chk("bus_stb", bus_stb_o, e_cyc);
      chk("done", done_o, e_done);
      chk("llbit", llbit_o, m_llbit);
      if (e_cyc && bus_cyc_o) begin
        chk("bus_we", bus_we_o, e_we);
        chk("bus_adr", bus_adr_o, e_adr);
        chk("bus_sel", bus_sel_o, e_sel);
        if (e_we) chk("bus_dat", bus_dat_o, e_dat);
      end
      if (e_done && done_o) begin
        chk("exc", exc_o, e_exc);
        if (e_rdchk) chk("rdata", rdata_o, e_rdata);
        if (e_exc == 2'd1 || e_exc == 2'd2)
          chk("badvaddr", badvaddr_o, e_badv);
      end
    end
    if (bus_cyc_o && !prev_cyc) begin
      cyc_rise = cyc_n;
      ncyc = 0;
    end
    if (bus_cyc_o) begin
      ncyc++;
      last_sel = bus_sel_o;
      last_dat = bus_dat_o;
    end
    prev_cyc = bus_cyc_o;
    if (done_o) begin
      done_at    = cyc_n;
      last_rdata = rdata_o;
      last_exc   = exc_o;
      last_badv  = badvaddr_o;
    end
  end

  // resp: 0 ack, 1 err, 2 silent, 3 ack+err
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int waits, input int resp,
                       input int flush_bus, input bit flush_resp);
    bit bus, we, ldchk, fault, killed;
    logic [3:0] sel;
    logic [31:0] dat, ld;
    logic [1:0] mexc;
    int nbus;
    predict(op, addr, wd, rd, m_llbit, bus, we, sel, dat, mexc, ld, ldchk);
    req_valid_i = 1; op_i = op; addr_i = addr; wdata_i = wd;
    bus_dat_i = rd;
    e_stall = 1; e_cyc = 0; e_done = 0;
    acc_at = cyc_n;
    @(posedge clk); #1;
    killed = 0; fault = 0;
    if (bus) begin
      e_cyc = 1; e_we = we; e_adr = {addr[31:2], 2'b00};
      e_sel = sel; e_dat = dat;
      nbus = (resp == 2) ? TMO : waits + 1;
      for (int w = 0; w < nbus; w++) begin
        e_stall = 1;
        if (w == nbus - 1 && resp != 2) begin
          bus_ack_i = (resp == 0 || resp == 3);
          bus_err_i = (resp == 1 || resp == 3);
        end
        if (w == flush_bus) begin
          flush_i = 1;
          killed = 1;
        end
        @(posedge clk); #1;
        bus_ack_i = 0; bus_err_i = 0; flush_i = 0;
      end
      fault = (resp != 0);
      e_cyc = 0;
      if (!killed && !fault) begin
        if (op == LL) m_llbit = 1;
        if (op == SC) m_llbit = 0;
      end
    end
    req_valid_i = 0; op_i = NONE;
    e_stall = 0;
    if (!killed) begin
      e_done  = !flush_resp;
      e_exc   = bus ? (fault ? 2'd3 : 2'd0) : mexc;
      e_rdata = (bus && fault) ? 32'd0 : ld;
      e_rdchk = (ldchk || fault) && (e_exc == 2'd0 || e_exc == 2'd3);
      e_badv  = addr;
      flush_i = flush_resp;
      @(posedge clk); #1;
      flush_i = 0;
      e_done = 0;
    end
  endtask

  task automatic no_acc(input logic [3:0] op, input bit ex, input bit fl);
    req_valid_i = 1; op_i = op; addr_i = 32'h6000;
    except_i = ex; flush_i = fl;
    e_stall = 0; e_cyc = 0; e_done = 0;
    @(posedge clk); #1;
    req_valid_i = 0; op_i = NONE; except_i = 0; flush_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic clr_ll();
    llbit_clr_i = 1;
    e_stall = 0; e_cyc = 0; e_done = 0;
    @(posedge clk); #1;
    llbit_clr_i = 0;
    m_llbit = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; req_valid_i = 0; op_i = NONE; addr_i = 0; wdata_i = 0;
    except_i = 0; flush_i = 0; llbit_clr_i = 0;
    bus_dat_i = 0; bus_ack_i = 0; bus_err_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", bus_cyc_o, 0);
    chk("rst_stb", bus_stb_o, 0);
    chk("rst_we", bus_we_o, 0);
    chk("rst_adr", bus_adr_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    chk("rst_dat", bus_dat_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_exc", exc_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_badv", badvaddr_o, 0);
    chk("rst_llbit", llbit_o, 0);
    chk("rst_stall", stallreq_o, 0);
    rst = 0;
    e_stall = 0; e_cyc = 0; e_done = 0;
    chk_en = 1;
    @(posedge clk); #1;

    do_op(LB, 32'h1001, 0, 32'h1280FF34, 0, 0, -1, 0);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    chk("lb_sel", last_sel, 4'b0100);
    chk("lb_latency", done_at - acc_at, 2);
    do_op(LBU, 32'h1001, 0, 32'h1280FF34, 0, 0, -1, 0);
    chk("lbu_rdata", last_rdata, 32'h00000080);

    do_op(LH, 32'h1003, 0, 32'h1280FF34, 0, 0, -1, 0);
    chk("lh_mis_exc", last_exc, 1);
    chk("lh_mis_badv", last_badv, 32'h1003);
    chk("lh_mis_latency", done_at - acc_at, 1);
    do_op(LH, 32'h1002, 0, 32'h1280FF34, 0, 0, -1, 0);
    chk("lh_rdata", last_rdata, 32'hFFFFFF34);
    do_op(LHU, 32'h1000, 0, 32'h1280FF34, 1, 0, -1, 0);
    chk("lhu_rdata", last_rdata, 32'h00001280);
    do_op(LW, 32'h1004, 0, 32'hCAFEF00D, 0, 0, -1, 0);

    do_op(SH, 32'h2002, 32'hABCD1234, 0, 3, 0, -1, 0);
    chk("sh_dat", last_dat, 32'h12341234);
    chk("sh_sel", last_sel, 4'b0011);
    chk("sh_done_after_cyc", done_at - cyc_rise, 4);
    do_op(SB, 32'h2003, 32'h000000A5, 0, 0, 0, -1, 0);
    chk("sb_dat", last_dat, 32'hA5A5A5A5);
    chk("sb_sel", last_sel, 4'b0001);
    do_op(SW, 32'h2008, 32'h89ABCDEF, 0, 1, 0, -1, 0);
    do_op(SW, 32'h2002, 32'h1, 0, 0, 0, -1, 0);
    chk("sw_mis_exc", last_exc, 2);
    do_op(SW, 32'h200C, 32'h5, 0, 0, 1, -1, 0);
    chk("sw_err_exc", last_exc, 3);

    do_op(LL, 32'h3000, 0, 32'hDEADBEEF, 0, 0, -1, 0);
    chk("ll_llbit", llbit_o, 1);
    do_op(LL, 32'h3002, 0, 0, 0, 0, -1, 0);
    chk("ll_mis_exc", last_exc, 1);
    chk("ll_mis_keep", llbit_o, 1);
    do_op(SC, 32'h3000, 32'h55, 0, 0, 0, -1, 0);
    chk("sc_ok_rdata", last_rdata, 1);
    chk("sc_ok_llbit", llbit_o, 0);
    do_op(SC, 32'h3000, 32'h66, 0, 0, 0, -1, 0);
    chk("sc_fail_rdata", last_rdata, 0);
    chk("sc_fail_latency", done_at - acc_at, 1);
    do_op(LL, 32'h3000, 0, 32'h7, 0, 0, -1, 0);
    clr_ll();
    do_op(SC, 32'h3000, 32'h77, 0, 0, 0, -1, 0);
    chk("sc_clr_rdata", last_rdata, 0);

    do_op(LW, 32'h4000, 0, 32'h1, 0, 2, -1, 0);
    chk("tmo_exc", last_exc, 3);
    chk("tmo_cyc_count", ncyc, TMO);
    do_op(LW, 32'h4004, 0, 32'h2, 0, 3, -1, 0);
    chk("ackerr_exc", last_exc, 3);

    do_op(LL, 32'h3000, 0, 32'h9, 2, 0, 0, 0);
    chk("kill_llbit", llbit_o, 0);
    do_op(LW, 32'h5000, 0, 32'h11223344, 0, 0, -1, 0);
    chk("post_kill_rdata", last_rdata, 32'h11223344);
    chk("post_kill_latency", done_at - acc_at, 2);

    do_op(LH, 32'h1001, 0, 0, 0, 0, -1, 1);
    no_acc(NONE, 0, 0);
    no_acc(4'd11, 0, 0);
    no_acc(LW, 1, 0);
    no_acc(LW, 0, 1);

    do_op(LL, 32'h3000, 0, 32'h3, 0, 0, -1, 0);
    req_valid_i = 1; op_i = LW; addr_i = 32'h7000; wdata_i = 0;
    e_stall = 1; e_cyc = 0; e_done = 0;
    @(posedge clk); #1;
    e_cyc = 1; e_we = 0; e_adr = 32'h7000; e_sel = 4'hF;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; req_valid_i = 0; op_i = NONE;
    e_cyc = 0; e_stall = 0; m_llbit = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_cyc", bus_cyc_o, 0);
    chk("midrst_llbit", llbit_o, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
